// File: rtl/rggen_atomic_register_common.sv
// -----------------------------------------------------------------------------
// rggen_atomic_register_common
//
// Register front-end for registers wider than the bus (DATA_WIDTH = N*BUS_WIDTH)
// that gives software atomic multi-word access:
//   - writes to the lower words are staged and committed to the bit fields
//     together with the write of the highest word;
//   - a read of word 0 captures the upper words into a snapshot so that the
//     following upper-word reads return a coherent value.
// One instance per register, between the bus demux and the bit fields.
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_register_valid          bus request valid
//   i_register_access         bit0: 1=write, 0=read
//   i_register_address        byte address
//   i_register_write_data     bus write data
//   i_register_strobe         per-bit write strobe
//   o_register_active         address/access hits a word of this register
//   o_register_ready          completes this cycle (equals active)
//   o_register_status         always OKAY (2'b00)
//   o_register_read_data      read data of the matched word
//   o_register_value          current register value (pass-through)
//   i_additional_match        extra decode qualifier
//   o_bit_field_valid         bit-field access strobe
//   o_bit_field_read_mask     bit-field read mask
//   o_bit_field_write_mask    bit-field write mask
//   o_bit_field_write_data    bit-field write data
//   i_bit_field_read_data     read data from the bit fields
//   i_bit_field_value         current value from the bit fields
//   o_staging_pending         staging buffer holds uncommitted bits
// -----------------------------------------------------------------------------
module rggen_atomic_register_common #(
    parameter bit                     READABLE       = 1'b1,
    parameter bit                     WRITABLE       = 1'b1,
    parameter int                     ADDRESS_WIDTH  = 8,
    parameter bit [ADDRESS_WIDTH-1:0] OFFSET_ADDRESS = '0,
    parameter int                     BUS_WIDTH      = 32,
    parameter int                     DATA_WIDTH     = BUS_WIDTH,
    parameter bit                     STAGED_WRITE   = 1'b1,
    parameter bit                     SNAPSHOT_READ  = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_register_valid,
    input  logic [1:0]               i_register_access,
    input  logic [ADDRESS_WIDTH-1:0] i_register_address,
    input  logic [BUS_WIDTH-1:0]     i_register_write_data,
    input  logic [BUS_WIDTH-1:0]     i_register_strobe,
    output logic                     o_register_active,
    output logic                     o_register_ready,
    output logic [1:0]               o_register_status,
    output logic [BUS_WIDTH-1:0]     o_register_read_data,
    output logic [DATA_WIDTH-1:0]    o_register_value,
    input  logic                     i_additional_match,
    output logic                     o_bit_field_valid,
    output logic [DATA_WIDTH-1:0]    o_bit_field_read_mask,
    output logic [DATA_WIDTH-1:0]    o_bit_field_write_mask,
    output logic [DATA_WIDTH-1:0]    o_bit_field_write_data,
    input  logic [DATA_WIDTH-1:0]    i_bit_field_read_data,
    input  logic [DATA_WIDTH-1:0]    i_bit_field_value,
    output logic                     o_staging_pending
);

    localparam int WORDS     = DATA_WIDTH / BUS_WIDTH;
    localparam int LAST      = WORDS - 1;
    // staging/snapshot arrays cover words 0..WORDS-2 (staging) and 1..WORDS-1
    // (snapshot); keep at least one entry so WORDS=1 still elaborates
    localparam int SW        = (WORDS > 1) ? WORDS - 1 : 1;
    localparam bit USE_STAGE = STAGED_WRITE  && (WORDS > 1);
    localparam bit USE_SNAP  = SNAPSHOT_READ && (WORDS > 1);

    logic                          is_write;
    logic [WORDS-1:0]              word_match;
    logic                          access;
    logic                          commit;
    logic                          stage_write;
    logic                          snap_take;
    logic                          snap_hit;
    logic                          top_write;

    logic [SW-1:0][BUS_WIDTH-1:0]  stage_data;
    logic [SW-1:0][BUS_WIDTH-1:0]  stage_mask;
    logic [SW-1:0][BUS_WIDTH-1:0]  snapshot;
    logic                          snap_valid;

    logic [DATA_WIDTH-1:0]         commit_mask;
    logic [DATA_WIDTH-1:0]         commit_data;

    logic                          unused_access_bit;
    assign unused_access_bit = i_register_access[1];

    assign is_write = i_register_access[0];

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < WORDS; i++) begin
            word_match[i] = i_additional_match &&
                            (is_write ? WRITABLE : READABLE) &&
                            (i_register_address ==
                             (OFFSET_ADDRESS + ADDRESS_WIDTH'(i * (BUS_WIDTH / 8))));
        end
    end

    assign o_register_active = |word_match;
    assign o_register_ready  = |word_match;
    assign o_register_status = 2'b00;
    assign o_register_value  = i_bit_field_value;
    assign access            = i_register_valid && (|word_match);

    assign top_write   = access && is_write && word_match[LAST];
    assign commit      = USE_STAGE && top_write;
    assign stage_write = USE_STAGE && access && is_write && !word_match[LAST];
    assign snap_take   = USE_SNAP && access && !is_write && word_match[0];
    // snap_valid is constant 0 when snapshots are disabled
    assign snap_hit    = access && !is_write && snap_valid && !word_match[0];

    // ------------------------------------------------------------------
    // Commit vectors: staged lower words plus the live top word
    // ------------------------------------------------------------------
    always_comb begin
        commit_mask = '0;
        commit_data = '0;
        for (int i = 0; i < LAST; i++) begin
            commit_mask[i*BUS_WIDTH +: BUS_WIDTH] = stage_mask[i];
            commit_data[i*BUS_WIDTH +: BUS_WIDTH] = stage_data[i];
        end
        commit_mask[LAST*BUS_WIDTH +: BUS_WIDTH] = i_register_strobe;
        commit_data[LAST*BUS_WIDTH +: BUS_WIDTH] = i_register_write_data;
    end

    // ------------------------------------------------------------------
    // Bit-field side
    // ------------------------------------------------------------------
    always_comb begin
        o_bit_field_valid      = 1'b0;
        o_bit_field_read_mask  = '0;
        o_bit_field_write_mask = '0;
        o_bit_field_write_data = {WORDS{i_register_write_data}};
        if (access) begin
            if (is_write) begin
                if (commit) begin
                    o_bit_field_valid      = 1'b1;
                    o_bit_field_write_mask = commit_mask;
                    o_bit_field_write_data = commit_data;
                end else if (!USE_STAGE) begin
                    o_bit_field_valid = 1'b1;
                    for (int i = 0; i < WORDS; i++) begin
                        if (word_match[i]) begin
                            o_bit_field_write_mask[i*BUS_WIDTH +: BUS_WIDTH] = i_register_strobe;
                        end
                    end
                end
            end else if (!snap_hit) begin
                o_bit_field_valid = 1'b1;
                if (snap_take) begin
                    // one read side effect covering the whole register
                    o_bit_field_read_mask = {WORDS{i_register_strobe}};
                end else begin
                    for (int i = 0; i < WORDS; i++) begin
                        if (word_match[i]) begin
                            o_bit_field_read_mask[i*BUS_WIDTH +: BUS_WIDTH] = i_register_strobe;
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus read data; upper words come from the snapshot while it is valid
    // ------------------------------------------------------------------
    always_comb begin
        o_register_read_data = '0;
        if (word_match[0] && !is_write) begin
            o_register_read_data = i_bit_field_read_data[0 +: BUS_WIDTH];
        end
        for (int i = 1; i < WORDS; i++) begin
            if (word_match[i] && !is_write) begin
                o_register_read_data = snap_valid ? snapshot[i-1]
                                                  : i_bit_field_read_data[i*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // Staging buffer
    // ------------------------------------------------------------------
    generate
        if (USE_STAGE) begin : g_stage
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    stage_data <= '0;
                    stage_mask <= '0;
                end else if (commit) begin
                    // stale data is harmless once its mask is gone
                    stage_mask <= '0;
                end else if (stage_write) begin
                    for (int i = 0; i < LAST; i++) begin
                        if (word_match[i]) begin
                            stage_data[i] <= (stage_data[i] & ~i_register_strobe) |
                                             (i_register_write_data & i_register_strobe);
                            stage_mask[i] <= stage_mask[i] | i_register_strobe;
                        end
                    end
                end
            end
        end else begin : g_no_stage
            assign stage_data = '0;
            assign stage_mask = '0;
        end
    endgenerate

    assign o_staging_pending = |stage_mask;

    // ------------------------------------------------------------------
    // Read snapshot
    // ------------------------------------------------------------------
    generate
        if (USE_SNAP) begin : g_snap
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    snapshot   <= '0;
                    snap_valid <= 1'b0;
                end else if (snap_take) begin
                    for (int i = 1; i < WORDS; i++) begin
                        snapshot[i-1] <= i_bit_field_read_data[i*BUS_WIDTH +: BUS_WIDTH];
                    end
                    snap_valid <= 1'b1;
                end else if (top_write || (snap_hit && word_match[LAST])) begin
                    // a commit makes the captured value stale; reading the top
                    // word ends the coherent read sequence
                    snap_valid <= 1'b0;
                end
            end
        end else begin : g_no_snap
            assign snapshot   = '0;
            assign snap_valid = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_rggen_atomic_register_common.sv
// -----------------------------------------------------------------------------
// Bench for rggen_atomic_register_common, 64-bit register on a 32-bit bus at
// offset 0x10. Directed scenarios first, then random traffic compared against
// a word-level model of staging and snapshot behaviour. A second instance
// with READABLE=0 shares the inputs.
// -----------------------------------------------------------------------------
module tb_rggen_atomic_register_common;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_register_valid;
    logic [1:0]  i_register_access;
    logic [7:0]  i_register_address;
    logic [31:0] i_register_write_data;
    logic [31:0] i_register_strobe;
    logic        i_additional_match;
    logic [63:0] i_bit_field_read_data;
    logic [63:0] i_bit_field_value;

    logic        o_register_active, o_register_ready;
    logic [1:0]  o_register_status;
    logic [31:0] o_register_read_data;
    logic [63:0] o_register_value;
    logic        o_bit_field_valid;
    logic [63:0] o_bit_field_read_mask, o_bit_field_write_mask, o_bit_field_write_data;
    logic        o_staging_pending;

    logic        u2_active, u2_ready;
    logic [1:0]  u2_status;
    logic [31:0] u2_read_data;
    logic [63:0] u2_value;
    logic        u2_valid;
    logic [63:0] u2_read_mask, u2_write_mask, u2_write_data;
    logic        u2_pending;

    int n_checks = 0;
    int n_pass   = 0;

    rggen_atomic_register_common #(
        .ADDRESS_WIDTH(8), .OFFSET_ADDRESS(8'h10), .BUS_WIDTH(32), .DATA_WIDTH(64)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_register_valid(i_register_valid), .i_register_access(i_register_access),
        .i_register_address(i_register_address), .i_register_write_data(i_register_write_data),
        .i_register_strobe(i_register_strobe),
        .o_register_active(o_register_active), .o_register_ready(o_register_ready),
        .o_register_status(o_register_status), .o_register_read_data(o_register_read_data),
        .o_register_value(o_register_value), .i_additional_match(i_additional_match),
        .o_bit_field_valid(o_bit_field_valid), .o_bit_field_read_mask(o_bit_field_read_mask),
        .o_bit_field_write_mask(o_bit_field_write_mask), .o_bit_field_write_data(o_bit_field_write_data),
        .i_bit_field_read_data(i_bit_field_read_data), .i_bit_field_value(i_bit_field_value),
        .o_staging_pending(o_staging_pending)
    );

    rggen_atomic_register_common #(
        .READABLE(1'b0), .ADDRESS_WIDTH(8), .OFFSET_ADDRESS(8'h10), .BUS_WIDTH(32), .DATA_WIDTH(64)
    ) u_noread (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_register_valid(i_register_valid), .i_register_access(i_register_access),
        .i_register_address(i_register_address), .i_register_write_data(i_register_write_data),
        .i_register_strobe(i_register_strobe),
        .o_register_active(u2_active), .o_register_ready(u2_ready),
        .o_register_status(u2_status), .o_register_read_data(u2_read_data),
        .o_register_value(u2_value), .i_additional_match(i_additional_match),
        .o_bit_field_valid(u2_valid), .o_bit_field_read_mask(u2_read_mask),
        .o_bit_field_write_mask(u2_write_mask), .o_bit_field_write_data(u2_write_data),
        .i_bit_field_read_data(i_bit_field_read_data), .i_bit_field_value(i_bit_field_value),
        .o_staging_pending(u2_pending)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    // model state: word 0 staging, word 1 snapshot
    logic [31:0] m_stage_data, m_stage_mask, m_snap;
    logic        m_snap_valid;

    // stimulus of the current cycle
    logic        s_rst, s_v, s_wr, s_am;
    logic [7:0]  s_addr;
    logic [31:0] s_wd, s_strb;
    logic [63:0] s_rd;

    task automatic model_reset();
        m_stage_data = '0;
        m_stage_mask = '0;
        m_snap       = '0;
        m_snap_valid = 1'b0;
    endtask

    function automatic int word_of(input logic [7:0] a);
        if (a == 8'h10) return 0;
        if (a == 8'h14) return 1;
        return -1;
    endfunction

    // Apply one cycle of stimulus and compare all outputs against the model.
    task automatic drive(input logic rst, input logic v, input logic wr, input logic [7:0] addr,
                         input logic [31:0] wd, input logic [31:0] strb,
                         input logic [63:0] rd, input logic am);
        int          w;
        logic        act, fire, e_valid;
        logic [63:0] e_rmask, e_wmask, e_wdata;
        logic [31:0] e_rdata;
        @(negedge i_clk);
        s_rst = rst; s_v = v; s_wr = wr; s_addr = addr; s_wd = wd; s_strb = strb; s_rd = rd; s_am = am;
        i_rst_n               = rst;
        i_register_valid      = v;
        i_register_access     = {1'($urandom_range(0, 1)), wr};
        i_register_address    = addr;
        i_register_write_data = wd;
        i_register_strobe     = strb;
        i_bit_field_read_data = rd;
        i_bit_field_value     = {$urandom, $urandom};
        i_additional_match    = am;
        if (!rst) model_reset();
        #1;
        w       = word_of(addr);
        act     = am && (w >= 0);
        fire    = v && act;
        e_valid = 1'b0;
        e_rmask = '0;
        e_wmask = '0;
        e_wdata = {wd, wd};
        e_rdata = '0;
        if (act && !wr) e_rdata = (w == 1 && m_snap_valid) ? m_snap : ((w == 1) ? rd[63:32] : rd[31:0]);
        if (fire && wr && w == 1) begin
            e_valid = 1'b1;
            e_wmask = {strb, m_stage_mask};
            e_wdata = {wd, m_stage_data};
        end
        if (fire && !wr) begin
            if (w == 0) begin
                e_valid = 1'b1;
                e_rmask = {strb, strb};
            end else if (!m_snap_valid) begin
                e_valid = 1'b1;
                e_rmask = {strb, 32'h0};
            end
        end
        check("active",  64'(o_register_active), 64'(act));
        check("ready",   64'(o_register_ready), 64'(act));
        check("status",  64'(o_register_status), 64'd0);
        check("value",   o_register_value, i_bit_field_value);
        check("valid",   64'(o_bit_field_valid), 64'(e_valid));
        check("rmask",   o_bit_field_read_mask, e_rmask);
        check("wmask",   o_bit_field_write_mask, e_wmask);
        check("wdata",   o_bit_field_write_data, e_wdata);
        check("rdata",   64'(o_register_read_data), 64'(e_rdata));
        check("pending", 64'(o_staging_pending), 64'(m_stage_mask != 0));
    endtask

    // Advance through the clock edge and update the model.
    task automatic step();
        int w;
        @(posedge i_clk);
        if (s_rst) begin
            w = word_of(s_addr);
            if (s_v && s_am && w >= 0) begin
                if (s_wr && w == 0) begin
                    m_stage_data = (m_stage_data & ~s_strb) | (s_wd & s_strb);
                    m_stage_mask = m_stage_mask | s_strb;
                end else if (s_wr && w == 1) begin
                    m_stage_mask = '0;
                    m_snap_valid = 1'b0;
                end else if (!s_wr && w == 0) begin
                    m_snap       = s_rd[63:32];
                    m_snap_valid = 1'b1;
                end else if (!s_wr && w == 1) begin
                    m_snap_valid = 1'b0;
                end
            end
        end
    endtask

    task automatic cyc(input logic rst, input logic v, input logic wr, input logic [7:0] addr,
                       input logic [31:0] wd, input logic [31:0] strb,
                       input logic [63:0] rd, input logic am);
        drive(rst, v, wr, addr, wd, strb, rd, am);
        step();
    endtask

    logic [7:0] addr_pool [5];

    initial begin
        i_rst_n = 1'b0; i_register_valid = 1'b0; i_register_access = '0;
        i_register_address = '0; i_register_write_data = '0; i_register_strobe = '0;
        i_additional_match = 1'b1; i_bit_field_read_data = '0; i_bit_field_value = '0;
        model_reset();
        addr_pool[0] = 8'h10; addr_pool[1] = 8'h14; addr_pool[2] = 8'h18;
        addr_pool[3] = 8'h0C; addr_pool[4] = 8'h11;

        // reset state
        drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 64'h0, 1'b1);
        check("rst_pending", 64'(o_staging_pending), 64'd0);
        check("rst_valid", 64'(o_bit_field_valid), 64'd0);
        step();
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 64'h0, 1'b1);

        // 1: staged write then commit
        drive(1'b1, 1'b1, 1'b1, 8'h10, 32'h11223344, 32'hFFFFFFFF, 64'h0, 1'b1);
        check("t1_stage_valid", 64'(o_bit_field_valid), 64'd0);
        step();
        drive(1'b1, 1'b1, 1'b1, 8'h14, 32'hAABBCCDD, 32'hFFFFFFFF, 64'h0, 1'b1);
        check("t1_pending", 64'(o_staging_pending), 64'd1);
        check("t1_commit_valid", 64'(o_bit_field_valid), 64'd1);
        check("t1_commit_mask", o_bit_field_write_mask, 64'hFFFFFFFF_FFFFFFFF);
        check("t1_commit_data", o_bit_field_write_data, 64'hAABBCCDD_11223344);
        step();
        drive(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 64'h0, 1'b1);
        check("t1_pending_clr", 64'(o_staging_pending), 64'd0);
        step();

        // 2: partial strobe, commit with zero top strobe
        cyc(1'b1, 1'b1, 1'b1, 8'h10, 32'h00001234, 32'h0000FFFF, 64'h0, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 8'h14, 32'h0, 32'h0, 64'h0, 1'b1);
        check("t2_commit_mask", o_bit_field_write_mask, 64'h00000000_0000FFFF);
        check("t2_commit_data", o_bit_field_write_data & 64'hFFFF, 64'h1234);
        step();

        // 3: coherent read via snapshot
        drive(1'b1, 1'b1, 1'b0, 8'h10, 32'h0, 32'hFFFFFFFF, 64'h00000001_FFFFFFFF, 1'b1);
        check("t3_rd0", 64'(o_register_read_data), 64'hFFFFFFFF);
        check("t3_rd0_valid", 64'(o_bit_field_valid), 64'd1);
        step();
        drive(1'b1, 1'b1, 1'b0, 8'h14, 32'h0, 32'hFFFFFFFF, 64'h00000002_00000000, 1'b1);
        check("t3_rd1", 64'(o_register_read_data), 64'h1);
        check("t3_rd1_valid", 64'(o_bit_field_valid), 64'd0);
        step();
        // 4: snapshot consumed, upper read is direct
        drive(1'b1, 1'b1, 1'b0, 8'h14, 32'h0, 32'hFFFFFFFF, 64'h00000002_00000000, 1'b1);
        check("t4_direct_valid", 64'(o_bit_field_valid), 64'd1);
        check("t4_direct_mask", o_bit_field_read_mask, 64'hFFFFFFFF_00000000);
        check("t4_direct_data", 64'(o_register_read_data), 64'h2);
        step();

        // 5: reset discards staged bytes
        cyc(1'b1, 1'b1, 1'b1, 8'h10, 32'hCAFEF00D, 32'hFFFFFFFF, 64'h0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 64'h0, 1'b1);
        check("t5_rst_pending", 64'(o_staging_pending), 64'd0);
        step();
        drive(1'b1, 1'b1, 1'b1, 8'h14, 32'h55AA55AA, 32'hFFFFFFFF, 64'h0, 1'b1);
        check("t5_commit_mask", o_bit_field_write_mask, 64'hFFFFFFFF_00000000);
        step();

        // 6: READABLE=0 instance
        drive(1'b1, 1'b1, 1'b0, 8'h10, 32'h0, 32'hFFFFFFFF, 64'h1, 1'b1);
        check("t6_active", 64'(u2_active), 64'd0);
        check("t6_ready", 64'(u2_ready), 64'd0);
        check("t6_valid", 64'(u2_valid), 64'd0);
        step();
        drive(1'b1, 1'b1, 1'b1, 8'h14, 32'h1, 32'hFFFFFFFF, 64'h0, 1'b1);
        check("t6_wr_active", 64'(u2_active), 64'd1);
        check("t6_wr_valid", 64'(u2_valid), 64'd1);
        step();

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            logic        rst, v, wr, am;
            logic [31:0] strb;
            rst = ($urandom_range(0, 99) != 0);
            v   = rst && ($urandom_range(0, 9) != 0);
            wr  = 1'($urandom_range(0, 1));
            am  = ($urandom_range(0, 9) != 0);
            case ($urandom_range(0, 3))
                0: strb = 32'hFFFFFFFF;
                1: strb = 32'h0;
                2: strb = $urandom;
                default: begin
                    strb = '0;
                    for (int b = 0; b < 4; b++)
                        if ($urandom_range(0, 1) != 0) strb[b*8 +: 8] = 8'hFF;
                end
            endcase
            cyc(rst, v, wr, addr_pool[$urandom_range(0, 4)], $urandom, strb,
                {$urandom, $urandom}, am);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
